// File: rtl/usb_ls_rx_if.sv
// Byte-level receive interface between the low-speed USB front end
// and the packet decoder.
interface usb_ls_rx_if;
  logic [7:0] rx_data;
  logic       rx_active;
  logic       rx_valid;
  logic       rx_error;

  modport master (
    output rx_data,
    output rx_active,
    output rx_valid,
    output rx_error
  );

  modport slave (
    input rx_data,
    input rx_active,
    input rx_valid,
    input rx_error
  );
endinterface

// File: rtl/usb_ls_rx.sv
// Low-speed USB receiver: clock recovery, SYNC detect, NRZI decode,
// bit unstuffing, byte assembly and EOP detection.
package usb_ls_rx_pkg;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;
endpackage

module usb_ls_rx
  import usb_ls_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned SAMPLE_PHASE   = 7,
  parameter int unsigned MIN_SYNC_ZEROS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  d_port_t          line_state,
  usb_ls_rx_if.master      rx
);

  localparam logic [3:0] PH_MAX = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] PH_SMP = 4'(SAMPLE_PHASE);
  localparam logic [2:0] Z_MIN  = 3'(MIN_SYNC_ZEROS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ABORT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  d_port_t    lst_q, lst_d;
  d_port_t    prev_q, prev_d;
  logic [2:0] zcnt_q, zcnt_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic       se0_q, se0_d;
  logic [7:0] data_q, data_d;
  logic       act_q, act_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;

  logic jk_edge;
  logic smp;
  logic jk;
  logic nrz;
  logic abort;

  always_comb begin
    state_d = state_q;
    lst_d   = line_state;
    prev_d  = prev_q;
    zcnt_d  = zcnt_q;
    ones_d  = ones_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    se0_d   = se0_q;
    data_d  = data_q;
    act_d   = act_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;

    jk_edge = (line_state == J && lst_q == K) ||
              (line_state == K && lst_q == J);
    // a sample landing on an edge belongs to the old bit alignment
    smp     = (phase_q == PH_SMP) && !jk_edge;
    jk      = (line_state == J) || (line_state == K);
    nrz     = (line_state == prev_q);

    if (jk_edge || phase_q == PH_MAX) phase_d = 4'd0;
    else                              phase_d = phase_q + 4'd1;

    if (smp) prev_d = line_state;

    unique case (state_q)
      S_IDLE: begin
        if (line_state == K && lst_q == J) begin
          state_d = S_SYNC;
          zcnt_d  = 3'd0;
        end
      end
      S_SYNC: begin
        if (smp) begin
          if (!jk) begin
            state_d = S_IDLE;
          end else if (!nrz) begin
            if (zcnt_q != 3'd7) zcnt_d = zcnt_q + 3'd1;
          end else if (zcnt_q >= Z_MIN) begin
            state_d = S_DATA;
            act_d   = 1'b1;
            ones_d  = 3'd1;
            bcnt_d  = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (smp) begin
          if (line_state == SE0) begin
            if (bcnt_q == 3'd0) state_d = S_EOP;
            else                abort   = 1'b1;
          end else if (line_state == SE1) begin
            abort = 1'b1;
          end else if (ones_q == 3'd6) begin
            if (nrz) abort  = 1'b1;
            else     ones_d = 3'd0;
          end else begin
            ones_d = nrz ? ones_q + 3'd1 : 3'd0;
            sh_d   = {nrz, sh_q[7:1]};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              data_d = {nrz, sh_q[7:1]};
              vld_d  = 1'b1;
            end
          end
        end
      end
      S_EOP: begin
        if (smp) begin
          if (line_state == J) begin
            act_d   = 1'b0;
            state_d = S_IDLE;
          end else if (line_state != SE0) begin
            abort = 1'b1;
          end
        end
      end
      S_ABORT: begin
        if (smp) begin
          unique case (line_state)
            SE0: begin
              se0_d  = 1'b1;
              zcnt_d = 3'd0;
            end
            J: begin
              if (se0_q || zcnt_q == 3'd7) begin
                act_d   = 1'b0;
                state_d = S_IDLE;
              end else begin
                zcnt_d = zcnt_q + 3'd1;
              end
            end
            default: zcnt_d = 3'd0;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_ABORT;
      vld_d   = 1'b1;
      err_d   = 1'b1;
      data_d  = sh_q;
      se0_d   = (line_state == SE0);
      zcnt_d  = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 4'd0;
      lst_q   <= J;
      prev_q  <= J;
      zcnt_q  <= 3'd0;
      ones_q  <= 3'd0;
      bcnt_q  <= 3'd0;
      sh_q    <= 8'h00;
      se0_q   <= 1'b0;
      data_q  <= 8'h00;
      act_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      lst_q   <= lst_d;
      prev_q  <= prev_d;
      zcnt_q  <= zcnt_d;
      ones_q  <= ones_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      se0_q   <= se0_d;
      data_q  <= data_d;
      act_q   <= act_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_active = act_q;
  assign rx.rx_valid  = vld_q;
  assign rx.rx_error  = err_q;

endmodule
